seq_fetch_master: RTL and testbench

//  Avalon-MM master loader that fills the 512x16 sequence RAM from system memory.

---
 rtl/seq_fetch_pkg.sv | 20 ++
 rtl/seq_fetch_csr.sv | 72 +++++++
 rtl/seq_fetch_master.sv | 239 +++++++++++++++++++++++
 tb/tb_seq_fetch_master.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_fetch_pkg.sv
// seq_fetch_pkg: shared FSM type, CSR map and control bit positions
// for the sequence RAM loader.
package seq_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CSR_BASE   = 2'd0;
    localparam logic [1:0] CSR_COUNT  = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int START_BIT = 31;
    localparam int ABORT_BIT = 30;

endpackage

// File: rtl/seq_fetch_csr.sv
// seq_fetch_csr: slave CSR registers, registered readback and
// start/abort pulses for the sequence RAM loader.
module seq_fetch_csr
    import seq_fetch_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    input  logic              busy,
    input  logic              irq_set,
    input  logic [ADDR_W:0]   received,
    output logic [31:0]       base,
    output logic [ADDR_W:0]   count,
    output logic              start_p,
    output logic              abort_p,
    output logic              done_irq
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    logic        wr;
    logic        rd;
    logic        ctrl_wr;
    logic [31:0] status;

    assign wr      = s_chipselect & s_write;
    assign rd      = s_chipselect & s_read;
    assign ctrl_wr = wr & (s_address == CSR_CTRL);
    assign abort_p = ctrl_wr & s_writedata[ABORT_BIT];
    // abort in the same write suppresses start
    assign start_p = ctrl_wr & s_writedata[START_BIT]
                   & ~s_writedata[ABORT_BIT];
    assign status  = {busy, done_irq, {(30-ADDR_W-1){1'b0}}, received};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            base       <= '0;
            count      <= '0;
            done_irq   <= 1'b0;
            s_readdata <= '0;
        end else begin
            if (wr && s_address == CSR_BASE)
                base <= {s_writedata[31:2], 2'b00};
            if (wr && s_address == CSR_COUNT) begin
                if (s_writedata > DEPTH)
                    count <= DEPTH[ADDR_W:0];
                else
                    count <= s_writedata[ADDR_W:0];
            end
            if (irq_set)
                done_irq <= 1'b1;
            else if (ctrl_wr)
                done_irq <= 1'b0;
            if (rd) begin
                unique case (s_address)
                    CSR_BASE:  s_readdata <= base;
                    CSR_COUNT: s_readdata <= 32'(count);
                    CSR_CTRL:  s_readdata <= '0;
                    default:   s_readdata <= status;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_fetch_master.sv
// seq_fetch_master: Avalon-MM read master that loads the sequence RAM.
// Define SEQ_FETCH_PACK_EN to unpack two 16-bit words per 32-bit read.
module seq_fetch_master
    import seq_fetch_pkg::*;
#(
    parameter int ADDR_W          = 9,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic [31:0]       m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic              done_irq
);

    localparam int            CW     = ADDR_W + 1;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [3:0]    MAX_OS = 4'(MAX_OUTSTANDING);

    state_t        state;
    logic [31:0]   base;
    logic [31:0]   base_l;
    logic [CW-1:0] count;
    logic [CW-1:0] count_l;
    logic [CW-1:0] n_reads;
    logic [CW-1:0] issued;
    logic [CW-1:0] received;
    logic [3:0]    outstanding;
    logic          start_p;
    logic          abort_p;
    logic          busy;
    logic          irq_set;
    logic          aborting;
    logic          accept;
    logic          drop;
    logic          start_go;

    seq_fetch_csr #(.ADDR_W(ADDR_W)) u_csr (
        .clock        (clock),
        .resetn       (resetn),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .busy         (busy),
        .irq_set      (irq_set),
        .received     (received),
        .base         (base),
        .count        (count),
        .start_p      (start_p),
        .abort_p      (abort_p),
        .done_irq     (done_irq)
    );

    assign busy     = state != S_IDLE;
    assign irq_set  = state == S_DONE;
    assign accept   = m_read & ~m_waitrequest;
    assign drop     = aborting | (abort_p & busy);
    assign start_go = start_p & (state == S_IDLE) & (count != '0);

`ifdef SEQ_FETCH_PACK_EN
    assign n_reads = (count_l + ONE) >> 1;
`else
    assign n_reads = count_l;
`endif

    assign m_read    = (state == S_ISSUE) & ~aborting
                     & (outstanding < MAX_OS) & (issued < n_reads);
    assign m_address = base_l + 32'({issued, 2'b00});

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            base_l   <= '0;
            count_l  <= '0;
            issued   <= '0;
            aborting <= 1'b0;
        end else begin
            if (accept)
                issued <= issued + ONE;
            unique case (state)
                S_IDLE: begin
                    if (start_p && count == '0) begin
                        state <= S_DONE;
                    end else if (start_p) begin
                        state   <= S_ISSUE;
                        base_l  <= base;
                        count_l <= count;
                        issued  <= '0;
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    // abort waits for in-flight reads before going idle
                    if (drop) begin
                        aborting <= 1'b1;
                        if (aborting && outstanding == '0) begin
                            state    <= S_IDLE;
                            aborting <= 1'b0;
                        end
                    end else if (state == S_ISSUE) begin
                        if (issued == n_reads)
                            state <= S_DRAIN;
                    end else if (received == count_l) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
        end else if (start_go) begin
            outstanding <= '0;
        end else begin
            unique case ({accept, m_readdatavalid})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef SEQ_FETCH_PACK_EN
    logic [DATA_W-1:0] skid [4];
    logic [1:0]        wp;
    logic [1:0]        rp;
    logic [2:0]        fill;
    logic [CW-1:0]     ret_words;
    logic              take;
    logic              has_hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

    assign take   = m_readdatavalid & ~drop & busy;
    assign lo     = m_readdata[DATA_W-1:0];
    assign hi     = m_readdata[2*DATA_W-1:DATA_W];
    assign has_hi = (ret_words + ONE) < count_l;

    // skid holds words not yet written so the RAM sees them in order
    always_ff @(posedge clock) begin
        if (take && fill != '0) begin
            skid[wp]        <= lo;
            skid[wp + 2'd1] <= hi;
        end else if (take) begin
            skid[wp] <= hi;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            received    <= '0;
            ret_words   <= '0;
            wp          <= '0;
            rp          <= '0;
            fill        <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (start_go || drop) begin
                wp   <= '0;
                rp   <= '0;
                fill <= '0;
                if (start_go) begin
                    received  <= '0;
                    ret_words <= '0;
                end
            end else begin
                if (fill != '0) begin
                    ram_wren    <= 1'b1;
                    ram_address <= received[ADDR_W-1:0];
                    ram_wdata   <= skid[rp];
                    received    <= received + ONE;
                    rp          <= rp + 2'd1;
                    if (take) begin
                        wp   <= wp + (has_hi ? 2'd2 : 2'd1);
                        fill <= fill + (has_hi ? 3'd1 : 3'd0);
                    end else begin
                        fill <= fill - 3'd1;
                    end
                end else if (take) begin
                    ram_wren    <= 1'b1;
                    ram_address <= received[ADDR_W-1:0];
                    ram_wdata   <= lo;
                    received    <= received + ONE;
                    if (has_hi) begin
                        wp   <= wp + 2'd1;
                        fill <= 3'd1;
                    end
                end
                if (take)
                    ret_words <= ret_words + (has_hi ? CW'(2) : ONE);
            end
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^m_readdata[31:DATA_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            received    <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (start_go) begin
                received <= '0;
            end else if (m_readdatavalid && !drop && busy) begin
                ram_wren    <= 1'b1;
                ram_address <= received[ADDR_W-1:0];
                ram_wdata   <= m_readdata[DATA_W-1:0];
                received    <= received + ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_fetch_master.sv
// tb_seq_fetch_master: scoreboard bench for the sequence RAM loader,
// driving an in-order Avalon slave with programmable latency and stalls.
`timescale 1ns/1ps
module tb_seq_fetch_master;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic [8:0]  ram_address;
    logic [15:0] ram_wdata;
    logic        ram_wren;
    logic        done_irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [8:0] a; logic [15:0] d; } wr_t;

    pend_t       pend[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_addr[$];

    int cyc = 0, n_acc = 0, n_ret = 0, outst = 0, max_out = 0;
    int ret_lat = 1, stall_idx = -1, stall_len = 0, stall_left = 0;
    int stall_hits = 0;
    logic [31:0] stall_addr = '0;
    bit chk_addr = 0;

    seq_fetch_master dut (
        .clock           (clock),
        .resetn          (resetn),
        .s_address       (s_address),
        .s_chipselect    (s_chipselect),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .ram_address     (ram_address),
        .ram_wdata       (ram_wdata),
        .ram_wren        (ram_wren),
        .done_irq        (done_irq)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'hC3A5};
    endfunction

    // slave model and output monitor
    initial begin
        logic        acc_s;
        logic [31:0] addr_s;
        logic [31:0] ea;
        wr_t         ew;
        pend_t       p;
        forever begin
            @(negedge clock);
            acc_s  = resetn && m_read && !m_waitrequest;
            addr_s = m_address;
            if (m_waitrequest && m_read && stall_len > 0) begin
                vectors++;
                stall_hits++;
                if (m_address !== stall_addr) begin
                    miscompares++;
                    $display("FAIL stall_hold: m_address=%h expected %h",
                             m_address, stall_addr);
                end
            end
            if (acc_s && chk_addr) begin
                vectors++;
                if (exp_addr.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_addr: unexpected accept at %h", addr_s);
                end else begin
                    ea = exp_addr.pop_front();
                    if (addr_s !== ea) begin
                        miscompares++;
                        $display("FAIL read_addr: got %h expected %h", addr_s, ea);
                    end
                end
            end
            if (ram_wren) begin
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL ram_write: unexpected write addr=%0d data=%h",
                             ram_address, ram_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    if (ram_address !== ew.a || ram_wdata !== ew.d) begin
                        miscompares++;
                        $display("FAIL ram_write: got %0d/%h expected %0d/%h",
                                 ram_address, ram_wdata, ew.a, ew.d);
                    end
                end
            end
            @(posedge clock);
            #1;
            cyc++;
            if (!resetn) begin
                pend.delete();
                outst = 0;
                m_readdatavalid = 1'b0;
                m_waitrequest = 1'b0;
                stall_left = 0;
                continue;
            end
            if (acc_s) begin
                pend.push_back('{addr: addr_s, due: cyc + ret_lat - 1});
                n_acc++;
                outst++;
                if (n_acc == stall_idx) stall_left = stall_len;
            end
            if (outst > max_out) max_out = outst;
            m_waitrequest = stall_left > 0;
            if (stall_left > 0) stall_left--;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                m_readdatavalid = 1'b1;
                m_readdata = mem_word(p.addr);
                outst--;
                n_ret++;
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata = $urandom;
            end
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s_chipselect = 1'b1;
        s_write      = 1'b1;
        s_address    = a;
        s_writedata  = d;
        @(posedge clock);
        #1;
        s_chipselect = 1'b0;
        s_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        s_chipselect = 1'b1;
        s_read       = 1'b1;
        s_address    = a;
        @(posedge clock);
        #1;
        s_chipselect = 1'b0;
        s_read       = 1'b0;
        d = s_readdata;
    endtask

    task automatic wait_irq(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (done_irq) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_acc(input int base_n, input int need, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (n_acc - base_n >= need) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_xfer(input logic [31:0] b, input int cnt,
                            input int lat, input int slen, input string nm);
        logic [31:0] d;
        logic [31:0] w;
        bit          ok;
        ret_lat    = lat;
        stall_len  = slen;
        stall_idx  = n_acc + 1;
        stall_hits = 0;
        stall_addr = b + 32'd4;
        max_out    = 0;
        csr_write(2'd2, 32'h0);
        csr_write(2'd0, b);
        csr_write(2'd1, 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(b + 32'(4 * i));
            w = mem_word(b + 32'(4 * i));
            exp_wr.push_back('{a: 9'(i), d: w[15:0]});
        end
        chk_addr = 1;
        csr_write(2'd2, 32'h8000_0000);
        wait_irq(400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_irq: done_irq=%b expected 1", nm, done_irq);
        end
        vectors++;
        if (exp_addr.size() != 0 || exp_wr.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d reads/%0d writes left, expected 0/0",
                     nm, exp_addr.size(), exp_wr.size());
        end
        csr_read(2'd3, d);
        vectors++;
        if (d !== {2'b01, 20'd0, 10'(cnt)}) begin
            miscompares++;
            $display("FAIL %s_status: got %h expected %h",
                     nm, d, {2'b01, 20'd0, 10'(cnt)});
        end
        chk_addr  = 0;
        stall_len = 0;
        exp_addr.delete();
        exp_wr.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        vectors++;
        if ({m_read, m_address, ram_wren, ram_address, ram_wdata,
             done_irq, s_readdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: m_read=%b m_address=%h ram_wren=%b irq=%b rd=%h expected all 0",
                     m_read, m_address, ram_wren, done_irq, s_readdata);
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        csr_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status: got %h expected 0", d);
        end
    endtask

    task automatic test_basic();
        run_xfer(32'h1000, 4, 1, 0, "basic");
        csr_write(2'd2, 32'h0);
        @(negedge clock);
        vectors++;
        if (done_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_irq_clear: done_irq=%b expected 0", done_irq);
        end
    endtask

    task automatic test_stall();
        run_xfer(32'h1000, 4, 1, 3, "stall");
        vectors++;
        if (stall_hits !== 3) begin
            miscompares++;
            $display("FAIL stall_cycles: held %0d cycles expected 3", stall_hits);
        end
    endtask

    task automatic test_outstanding();
        run_xfer(32'h3000, 10, 8, 0, "outst");
        vectors++;
        if (max_out !== 4) begin
            miscompares++;
            $display("FAIL outst_max: max outstanding %0d expected 4", max_out);
        end
    endtask

    task automatic test_count0();
        int a;
        csr_write(2'd2, 32'h0);
        csr_write(2'd1, 32'h0);
        a = n_acc;
        csr_write(2'd2, 32'h8000_0000);
        @(negedge clock);
        vectors++;
        if (m_read !== 1'b0) begin
            miscompares++;
            $display("FAIL count0_read: m_read=%b expected 0", m_read);
        end
        @(negedge clock);
        vectors++;
        if (done_irq !== 1'b1) begin
            miscompares++;
            $display("FAIL count0_irq: done_irq=%b expected 1", done_irq);
        end
        vectors++;
        if (n_acc !== a) begin
            miscompares++;
            $display("FAIL count0_acc: accepts %0d expected %0d", n_acc, a);
        end
        csr_write(2'd2, 32'h0);
        @(negedge clock);
        vectors++;
        if (done_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL count0_clear: done_irq=%b expected 0", done_irq);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] wv[5] = '{32'd1000, 32'd513, 32'd512, 32'd511, 32'd1};
        logic [31:0] ev[5] = '{32'd512, 32'd512, 32'd512, 32'd511, 32'd1};
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            csr_write(2'd1, wv[i]);
            csr_read(2'd1, d);
            vectors++;
            if (d !== ev[i]) begin
                miscompares++;
                $display("FAIL clamp_count: wrote %0d read %0d expected %0d",
                         wv[i], d, ev[i]);
            end
        end
        csr_write(2'd0, 32'h0000_1237);
        csr_read(2'd0, d);
        vectors++;
        if (d !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL base_align: got %h expected 00001234", d);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        bit          ok;
        int          a0;
        int          a1;
        ret_lat = 12;
        csr_write(2'd2, 32'h0);
        csr_write(2'd0, 32'h4000);
        csr_write(2'd1, 32'd8);
        a0 = n_acc;
        csr_write(2'd2, 32'h8000_0000);
        wait_acc(a0, 2, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL abort_start: accepts %0d expected >=2", n_acc - a0);
        end
        csr_write(2'd2, 32'h4000_0000);
        @(negedge clock);
        vectors++;
        if (m_read !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_read: m_read=%b expected 0", m_read);
        end
        a1 = n_acc;
        ok = 0;
        d  = '1;
        for (int i = 0; i < 100; i++) begin
            csr_read(2'd3, d);
            if (d[31] == 1'b0) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL abort_idle: status %h expected busy=0", d);
        end
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_status: got %h expected 0", d);
        end
        vectors++;
        if (n_acc !== a1) begin
            miscompares++;
            $display("FAIL abort_noissue: accepts %0d expected %0d", n_acc, a1);
        end
        vectors++;
        if (n_ret !== n_acc) begin
            miscompares++;
            $display("FAIL abort_returns: returned %0d expected %0d", n_ret, n_acc);
        end
        vectors++;
        if (done_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_irq: done_irq=%b expected 0", done_irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          ok;
        int          a0;
        ret_lat = 20;
        csr_write(2'd0, 32'h5000);
        csr_write(2'd1, 32'd8);
        a0 = n_acc;
        csr_write(2'd2, 32'h8000_0000);
        wait_acc(a0, 2, ok);
        vectors++;
        if (!ok || m_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_active: m_read=%b ok=%b expected 1/1", m_read, ok);
        end
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (m_read !== 1'b0 || m_address !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_async: m_read=%b m_address=%h expected 0/0",
                     m_read, m_address);
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        csr_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_status: got %h expected 0", d);
        end
        csr_read(2'd1, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_count: got %h expected 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_outstanding();
        test_count0();
        test_clamp();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
